// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 multi-cycle core: opcode constants,
// controller state and instruction-class encodings, and the ALU operation
// codes that the ALU control decoder also consumes.
package riscv_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      CLS_R      = 2'd0,
      CLS_LOAD   = 2'd1,
      CLS_STORE  = 2'd2,
      CLS_BRANCH = 2'd3
   } op_class_t;

endpackage

// File: rtl/riscv_op_decode.sv
// Opcode classifier: maps the 7-bit major opcode onto an instruction class
// and flags whether the opcode is one the controller can sequence.
module riscv_op_decode
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [1:0] op_class,
   output logic       valid
);

   // Unsupported opcodes report valid=0; the class value is then don't-care.
   always_comb begin
      op_class = CLS_R;
      valid    = 1'b1;
      case (opcode)
         OPC_RTYPE:  op_class = CLS_R;
         OPC_LOAD:   op_class = CLS_LOAD;
         OPC_STORE:  op_class = CLS_STORE;
         OPC_BRANCH: op_class = CLS_BRANCH;
         default:    valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle sequencing controller. Steps each instruction through
// fetch/decode/execute/memory/write-back over one shared memory port,
// drives every datapath strobe and select, counts retirements and halts
// permanently on an unsupported opcode.
module riscv_mc_ctrl
   import riscv_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [6:0]          opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_write,
   output logic                mdr_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                alu_src,
   output logic [1:0]          alu_op,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                busy,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired,
   output logic [2:0]          state
);

   state_t                state_q;
   state_t                state_next;
   op_class_t             op_class_q;
   logic                  illegal_q;
   logic [RETIRE_W-1:0]   retired_q;
   logic [1:0]            dec_class;
   logic                  dec_valid;
   logic                  retire;

   riscv_op_decode u_op_decode (
      .opcode   (opcode),
      .op_class (dec_class),
      .valid    (dec_valid)
   );

   // State, instruction class, sticky illegal flag and retire count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_class_q <= CLS_R;
         illegal_q  <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q <= state_next;
         if (state_q == ST_DECODE) begin
            if (dec_valid) begin
               op_class_q <= op_class_t'(dec_class);
            end else begin
               illegal_q <= 1'b1;
            end
         end
         if (retire) begin
            retired_q <= retired_q + RETIRE_W'(1);
         end
      end
   end

   // Next state and all strobes; anything not set in a state stays 0.
   always_comb begin
      state_next   = state_q;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_src      = 1'b0;
      alu_op       = ALU_OP_ADD;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_next = dec_valid ? ST_EXEC : ST_HALT;
         end
         ST_EXEC: begin
            case (op_class_q)
               CLS_R: begin
                  alu_op     = ALU_OP_FUNCT;
                  state_next = ST_WB;
               end
               CLS_LOAD, CLS_STORE: begin
                  alu_op     = ALU_OP_ADD;
                  alu_src    = 1'b1;
                  state_next = ST_MEM;
               end
               default: begin
                  alu_op   = ALU_OP_SUB;
                  pc_write = 1'b1;
                  pc_src   = zero;
                  retire   = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (op_class_q == CLS_STORE);
            alu_src      = 1'b1;
            if (mem_ready) begin
               if (op_class_q == CLS_LOAD) begin
                  mdr_write  = 1'b1;
                  state_next = ST_WB;
               end else begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_class_q == CLS_LOAD);
            pc_write   = 1'b1;
            retire     = 1'b1;
            if (op_class_q == CLS_R) alu_op = ALU_OP_FUNCT;
         end
         default: begin
            state_next = ST_HALT;
         end
      endcase
      // Instruction boundary: run is only consulted when one retires.
      if (retire) state_next = run ? ST_FETCH : ST_IDLE;
   end

   assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign illegal = illegal_q;
   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for the multi-cycle controller, built with a 4-bit retire
// counter so that counter wrap is reachable in a short run.
module tb_riscv_mc_ctrl;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic [6:0]    opcode;
   logic          zero;
   logic          mem_ready;
   logic          mem_req, mem_we, mem_addr_sel, ir_write, mdr_write;
   logic          pc_write, pc_src, alu_src, reg_write, mem_to_reg;
   logic          busy, illegal;
   logic [1:0]    alu_op;
   logic [RW-1:0] retired;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;

   riscv_mc_ctrl #(.RETIRE_W(RW)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .mdr_write(mdr_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy),
      .illegal(illegal), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; opcode = 7'h00; zero = 1'b0; mem_ready = 1'b0;
      tick(); tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_retired", 32'(retired), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_memreq", 32'(mem_req), 0);

      // R-type, memory always ready
      run = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
      reset = 1'b0;
      tick();
      chk("r_c1_state", 32'(state), 1);
      chk("r_c1_irw", 32'(ir_write), 1);
      chk("r_c1_memreq", 32'(mem_req), 1);
      tick();
      chk("r_c2_state", 32'(state), 2);
      tick();
      chk("r_c3_state", 32'(state), 3);
      chk("r_c3_aluop", 32'(alu_op), 2);
      chk("r_c3_alusrc", 32'(alu_src), 0);
      tick();
      chk("r_c4_state", 32'(state), 5);
      chk("r_c4_regw", 32'(reg_write), 1);
      chk("r_c4_pcw", 32'(pc_write), 1);
      chk("r_c4_m2r", 32'(mem_to_reg), 0);
      chk("r_c4_aluop", 32'(alu_op), 2);
      chk("r_c4_ret", 32'(retired), 0);
      tick();
      chk("r_c5_state", 32'(state), 1);
      chk("r_c5_ret", 32'(retired), 1);

      // LOAD with three wait cycles in MEM (this FETCH is cycle 1)
      opcode = 7'b0000011;
      tick();
      chk("ld_c2_state", 32'(state), 2);
      tick();
      chk("ld_c3_state", 32'(state), 3);
      chk("ld_c3_alusrc", 32'(alu_src), 1);
      chk("ld_c3_aluop", 32'(alu_op), 0);
      mem_ready = 1'b0;
      for (int c = 4; c <= 6; c++) begin
         tick();
         chk("ld_wait_state", 32'(state), 4);
         chk("ld_wait_req", 32'(mem_req), 1);
         chk("ld_wait_sel", 32'(mem_addr_sel), 1);
         chk("ld_wait_we", 32'(mem_we), 0);
         chk("ld_wait_mdr", 32'(mdr_write), 0);
      end
      tick();
      mem_ready = 1'b1;
      #1;
      chk("ld_c7_state", 32'(state), 4);
      chk("ld_c7_req", 32'(mem_req), 1);
      chk("ld_c7_mdr", 32'(mdr_write), 1);
      chk("ld_c7_pcw", 32'(pc_write), 0);
      tick();
      chk("ld_c8_state", 32'(state), 5);
      chk("ld_c8_m2r", 32'(mem_to_reg), 1);
      chk("ld_c8_regw", 32'(reg_write), 1);
      chk("ld_c8_pcw", 32'(pc_write), 1);
      tick();
      chk("ld_c9_state", 32'(state), 1);
      chk("ld_c9_ret", 32'(retired), 2);

      // BRANCH taken, then not taken
      opcode = 7'b1100011; zero = 1'b1;
      tick(); tick();
      chk("bt_state", 32'(state), 3);
      chk("bt_pcw", 32'(pc_write), 1);
      chk("bt_pcsrc", 32'(pc_src), 1);
      chk("bt_aluop", 32'(alu_op), 1);
      tick();
      chk("bt_next", 32'(state), 1);
      chk("bt_ret", 32'(retired), 3);
      zero = 1'b0;
      tick(); tick();
      chk("bn_pcw", 32'(pc_write), 1);
      chk("bn_pcsrc", 32'(pc_src), 0);
      tick();
      chk("bn_ret", 32'(retired), 4);

      // STORE with run dropped during EXEC
      opcode = 7'b0100011;
      tick(); tick();
      chk("st_exec", 32'(state), 3);
      run = 1'b0;
      tick();
      chk("st_mem_state", 32'(state), 4);
      chk("st_mem_we", 32'(mem_we), 1);
      chk("st_mem_pcw", 32'(pc_write), 1);
      tick();
      chk("st_idle", 32'(state), 0);
      chk("st_ret", 32'(retired), 5);
      chk("st_busy", 32'(busy), 0);
      chk("st_we_off", 32'(mem_we), 0);
      tick();
      chk("st_idle_hold", 32'(state), 0);

      // Eleven branches wrap the 4-bit counter from 5 to 0
      run = 1'b1; opcode = 7'b1100011; zero = 1'b0;
      tick();
      for (int i = 0; i < 11; i++) begin
         tick(); tick();
         if (i == 10) chk("wrap_pre", 32'(retired), 15);
         tick();
      end
      chk("wrap_ret", 32'(retired), 0);
      chk("wrap_state", 32'(state), 1);

      // Reset during a stalled MEM
      opcode = 7'b0000011;
      tick(); tick();
      mem_ready = 1'b0;
      tick();
      chk("rm_req_before", 32'(mem_req), 1);
      reset = 1'b1;
      #1;
      chk("rm_req", 32'(mem_req), 0);
      chk("rm_state", 32'(state), 0);
      chk("rm_ret", 32'(retired), 0);
      chk("rm_illegal", 32'(illegal), 0);

      // Illegal opcode halts until reset
      tick();
      mem_ready = 1'b1; opcode = 7'b1111111;
      reset = 1'b0;
      tick(); tick();
      chk("il_dec_busy", 32'(busy), 1);
      tick();
      chk("il_state", 32'(state), 6);
      chk("il_flag", 32'(illegal), 1);
      chk("il_busy", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         run = i[0]; mem_ready = i[1];
         tick();
         chk("il_hold_state", 32'(state), 6);
         chk("il_hold_req", 32'(mem_req), 0);
      end
      reset = 1'b1;
      #1;
      chk("il_rst_state", 32'(state), 0);
      chk("il_rst_flag", 32'(illegal), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle sequencing controller for the RV32 core datapath. It replaces the single-cycle decoder with a state machine. Each instruction is broken into fetch, decode, execute, memory and write-back steps over a shared, wait-stated memory port. The block drives every datapath enable and mux select, stalls on memory handshakes, counts retired instructions and halts on illegal opcodes.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 permits execution, sampled only at instruction boundaries
- opcode  in  7  instruction register bits [6:0]
- zero  in  1  ALU equality flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- mdr_write  out  1  load memory data register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- reg_write  out  1  register file write
- mem_to_reg  out  1  0 = ALU result, 1 = MDR
- busy  out  1  state not IDLE and not HALT
- illegal  out  1  sticky illegal-opcode flag
- retired  out  RETIRE_W  retired-instruction count
- state  out  3  current state encoding, for debug

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **IDLE**
  - All strobes 0.
  - run=1 → FETCH.
- **FETCH**
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - Hold while mem_ready=0.
  - On mem_ready=1: ir_write=1 in the same cycle, → DECODE.
- **DECODE**
  - Classify opcode into op_class register:
    - 0110011 → R
    - 0000011 → LOAD
    - 0100011 → STORE
    - 1100011 → BRANCH
  - Any other value: set illegal, → HALT.
  - Valid classes → EXEC.
  - Later states use op_class only, never opcode.
- **EXEC**
  - R: alu_op=10, alu_src=0, → WB.
  - LOAD/STORE: alu_op=00, alu_src=1, → MEM.
  - BRANCH: alu_op=01, alu_src=0, pc_write=1, pc_src=zero. The instruction retires; next state per the boundary rule.
- **MEM**
  - mem_req=1, mem_addr_sel=1, mem_we=(STORE); alu_op=00 and alu_src=1 held.
  - Hold while mem_ready=0.
  - On mem_ready=1:
    - LOAD: mdr_write=1, → WB.
    - STORE: pc_write=1, pc_src=0, retire.
- **WB**
  - reg_write=1, mem_to_reg=(LOAD), pc_write=1, pc_src=0, retire.
  - R-type keeps alu_op=10 and alu_src=0 so the result stays valid.
- **HALT**
  - Absorbing state; all strobes 0; run ignored.
  - Exit only by reset.
- **Boundary rule:** at retirement, next state is FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts that instruction.
- **Retire counter**
  - retired increments by 1 on each retiring cycle.
  - Wraps modulo 2^RETIRE_W with no flag.
- **Default values:** every strobe and select not listed for a state is 0.

## Timing
- Reset: asynchronous; takes effect immediately.
  - state=IDLE, op_class cleared, illegal=0, retired=0.
  - All outputs 0, including busy.
  - Reset mid-instruction discards the instruction; any memory request drops in the same instant.
- Registered: state, op_class, illegal, retired. All other outputs are combinational.
  - ir_write, mdr_write and the MEM-state pc_write depend combinationally on mem_ready.
  - pc_src in EXEC depends combinationally on zero.
- Latency with mem_ready tied 1, in cycles from entering FETCH to retirement:
  - BRANCH 3
  - R 4
  - STORE 4
  - LOAD 5
- Each wait cycle adds 1 cycle.
- The next FETCH begins in the cycle after retirement.
- mem_req stays asserted and mem_addr_sel/mem_we stay stable throughout a stalled request.
- A simultaneous retire and run=0 goes to IDLE, and the count still increments.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH)
  - the state enum
  - the op_class enum
  - ALU_OP_ADD/SUB/FUNCT encodings, also consumed by the ALU control decoder.
- One sub-module, riscv_op_decode: combinational opcode → {op_class, valid}, instantiated in the DECODE path.
- Everything else is in one FSM module: state register, output decode, retire counter.

## Test plan
- Reset asserted during a stalled MEM (mem_req=1) → mem_req drops to 0 before the next edge; state=0, retired=0, illegal=0.
- run=1, mem_ready=1, opcode=0110011 → states 1,2,3,5; reg_write=1 and pc_write=1 in the 4th cycle; retired 0→1; FETCH again in the 5th cycle.
- LOAD with mem_ready=0 for the first 3 MEM cycles → MEM lasts 4 cycles with mem_req=1, mem_addr_sel=1, mem_we=0 throughout; mdr_write asserted only in the ready cycle; retirement at cycle 8.
- BRANCH with zero=1 → in EXEC pc_write=1, pc_src=1, retired+1, retirement at cycle 3; repeat with zero=0 → pc_src=0.
- opcode=1111111 → HALT after DECODE; illegal=1, busy=0, state=6; toggling run and mem_ready has no effect until reset.
- run dropped during EXEC of a STORE → one mem_we=1 cycle in MEM, then IDLE; with RETIRE_W=4, 16 retirements return retired to 0.
